// File: rtl/fir_stream_filter.sv
// fir_stream_filter
//
// Streaming FIR filter stage. Samples arrive one per cycle over a
// valid/ready handshake, are combined with a delay line of the previous
// TAPS-1 accepted samples, multiplied by a run-time loadable coefficient
// bank, and summed through a pipelined binary adder tree at full
// precision. The sum is then rounded (half up), arithmetically shifted
// right by FRAC and saturated to OUT_W bits.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous, active-high reset
//   flush       synchronous clear of delay line and all stage valids
//   coef_wr_en  coefficient write strobe (independent of the handshake)
//   coef_addr   tap index to write
//   coef_data   coefficient value (signed)
//   in_valid    input sample valid
//   in_ready    block accepts a sample this cycle
//   in_data     input sample (signed)
//   out_valid   output sample valid
//   out_ready   downstream accepts the output sample
//   out_data    filtered sample (signed)
//   out_sat     out_data was clamped (qualified by out_valid)
//
// Pipeline: multiply -> $clog2(TAPS) adder levels -> round -> shift/clamp.
// Every stage advances on the single global enable, so a stalled output
// freezes the whole pipe and no bubbles are squeezed out. The latency from
// the accept edge to out_valid is $clog2(TAPS)+2 cycles.

module fir_stream_filter #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 8,
    parameter int FRAC   = 15,
    parameter int OUT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       coef_wr_en,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [DATA_W-1:0]   in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [OUT_W-1:0]    out_data,
    output logic                       out_sat
);

    localparam int LVLS   = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + LVLS;
    localparam int NODES  = 2 * TAPS - 1;
    // one extra bit so the rounding increment can never wrap the sum
    localparam int RND_W  = ACC_W + 1;

    localparam logic signed [RND_W-1:0] RND_ADD =
        (FRAC > 0) ? RND_W'(longint'(1) <<< ((FRAC > 0) ? FRAC - 1 : 0)) : '0;
    localparam logic signed [RND_W-1:0] OMAX =
        RND_W'((longint'(1) <<< (OUT_W - 1)) - 1);
    localparam logic signed [RND_W-1:0] OMIN =
        RND_W'(-(longint'(1) <<< (OUT_W - 1)));

    logic                      en;
    logic                      accept;

    logic signed [COEF_W-1:0]  coef [TAPS];
    logic signed [DATA_W-1:0]  dly  [TAPS-1];
    logic signed [DATA_W-1:0]  win  [TAPS];
    logic signed [PROD_W-1:0]  prod [TAPS];

    // Adder tree in heap layout: node[0] is the root, node[i] sums
    // node[2i+1] and node[2i+2], leaves node[TAPS-1..2*TAPS-2] hold the
    // registered products. Because all nodes load on the same enable, a
    // node at depth d lags the leaves by LVLS-d cycles.
    logic signed [ACC_W-1:0]   node [NODES];
    logic [LVLS:0]             vld;

    logic signed [RND_W-1:0]   rnd_q;
    logic                      rnd_vld;

    logic signed [RND_W-1:0]   shifted;
    logic signed [OUT_W-1:0]   clamp_val;
    logic                      clamp_hit;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en && !flush;

    // Tap 0 is the incoming sample; taps 1.. come from the delay line.
    always_comb begin
        win[0] = in_data;
        for (int i = 1; i < TAPS; i++) begin
            win[i] = dly[i-1];
        end
        for (int i = 0; i < TAPS; i++) begin
            prod[i] = PROD_W'(win[i]) * PROD_W'(coef[i]);
        end
    end

    // Coefficient bank. The multiply stage samples coef before this edge's
    // write lands, so a write never affects the sample accepted with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                coef[i] <= '0;
            end
        end else if (coef_wr_en) begin
            coef[coef_addr] <= coef_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS - 1; i++) begin
                dly[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < TAPS - 1; i++) begin
                dly[i] <= '0;
            end
        end else if (accept) begin
            dly[0] <= in_data;
            for (int i = 1; i < TAPS - 1; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    // Datapath registers: products, adder tree and rounding add.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NODES; i++) begin
                node[i] <= '0;
            end
            rnd_q <= '0;
        end else if (en) begin
            for (int i = 0; i < TAPS; i++) begin
                node[TAPS-1+i] <= ACC_W'(prod[i]);
            end
            for (int i = 0; i < TAPS - 1; i++) begin
                node[i] <= node[2*i+1] + node[2*i+2];
            end
            rnd_q <= RND_W'(node[0]) + RND_ADD;
        end
    end

    always_comb begin
        shifted   = rnd_q >>> FRAC;
        clamp_val = OUT_W'(shifted);
        clamp_hit = 1'b0;
        if (shifted > OMAX) begin
            clamp_val = OUT_W'(OMAX);
            clamp_hit = 1'b1;
        end else if (shifted < OMIN) begin
            clamp_val = OUT_W'(OMIN);
            clamp_hit = 1'b1;
        end
    end

    // Stage valids and the output register. Flush drops everything in
    // flight, including a sample currently presented downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld       <= '0;
            rnd_vld   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (flush) begin
            vld       <= '0;
            rnd_vld   <= 1'b0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
        end else if (en) begin
            vld       <= {vld[LVLS-1:0], accept};
            rnd_vld   <= vld[LVLS];
            out_valid <= rnd_vld;
            out_data  <= clamp_val;
            out_sat   <= rnd_vld && clamp_hit;
        end
    end

endmodule
